// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM/frame types, key labels, mode codes and the keypad position->label map
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;
  localparam logic [3:0] MODE_A = 4'b0001;
  localparam logic [3:0] MODE_B = 4'b0010;
  localparam logic [3:0] MODE_C = 4'b0100;
  localparam logic [3:0] MODE_D = 4'b1000;
  localparam logic [3:0] MODE_OFF = 4'b0000;
  // Nibble at position row*4+col is the printed label; position 0 is the LSB nibble.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] key_label(input logic [3:0] pos);
    return KEY_MAP[{pos, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-frame press/release debounce FSM; in: frame_stb, res, key; out: state, cand, confirm
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  frame_t     res,
  input  logic [3:0] key,
  output state_t     state,
  output logic [3:0] cand,
  output logic       confirm
);
  localparam logic [7:0] DF = 8'(DEBOUNCE_FRAMES);
  state_t state_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic [3:0] cand_n;
  assign cnt_inc = (cnt >= DF) ? cnt : cnt + 8'd1;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    confirm = 1'b0;
    if (frame_stb)
      case (state)
        IDLE:
          if (res == SINGLE) begin
            state_n = PRESS_CHK;
            cand_n = key;
            cnt_n = 8'd1;
          end
        PRESS_CHK:
          if (res != SINGLE) state_n = IDLE;
          else if (key != cand) begin
            cand_n = key;
            cnt_n = 8'd1;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == DF) begin
              state_n = HELD;
              confirm = 1'b1;
            end
          end
        HELD:
          if (res == NONE) begin
            state_n = RELEASE_CHK;
            cnt_n = 8'd1;
          end
        RELEASE_CHK:
          if (res != NONE) state_n = HELD;
          else begin
            cnt_n = cnt_inc;
            if (cnt_inc == DF) state_n = IDLE;
          end
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scan/debounce/decode; in: clk_50M, rst, row_in; out: col_out, key_code, key_valid, mode, BCD_preset
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_CNTMAX     = 49_999,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] mode,
  output logic [7:0] BCD_preset
);
  localparam int TW = $clog2(SCAN_CNTMAX + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_CNTMAX);
  logic [3:0] row_m, row_s, pos, cand;
  logic [TW-1:0] tick;
  logic [1:0] col;
  logic [15:0] snap, snap_n, pressed;
  logic tick_end, frame_stb, confirm, fire;
  frame_t res;
  state_t db_state;
  assign tick_end = tick == TICK_MAX;
  assign frame_stb = tick_end && col == 2'd3;
  assign col_out = ~(4'b0001 << col);
  // Snapshot including the column being sampled this cycle, so column 3 is evaluated without an extra frame of delay.
  always_comb begin
    snap_n = snap;
    for (int r = 0; r < 4; r++) snap_n[{r[1:0], col}] = row_s[r];
  end
  assign pressed = ~snap_n;
  always_comb begin
    pos = 4'd0;
    for (int i = 0; i < 16; i++) if (pressed[i]) pos = 4'(i);
  end
  assign res = pressed == '0 ? NONE : (pressed & (pressed - 16'd1)) == '0 ? SINGLE : MULTI;
  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk(clk_50M),
    .rst(rst),
    .frame_stb(frame_stb),
    .res(res),
    .key(key_label(pos)),
    .state(db_state),
    .cand(cand),
    .confirm(confirm)
  );
  assign fire = confirm && db_state == PRESS_CHK;
  always_ff @(posedge clk_50M)
    if (rst) begin
      row_m <= '1;
      row_s <= '1;
      tick <= '0;
      col <= '0;
      snap <= '1;
      key_code <= '0;
      key_valid <= 1'b0;
      mode <= MODE_OFF;
      BCD_preset <= 8'h00;
    end else begin
      row_m <= row_in;
      row_s <= row_m;
      tick <= tick_end ? '0 : tick + TW'(1);
      if (tick_end) begin
        col <= col + 2'd1;
        snap <= snap_n;
      end
      key_valid <= fire;
      if (fire) begin
        key_code <= cand;
        if (cand <= 4'd9) BCD_preset <= {BCD_preset[3:0], cand};
        else if (cand == KEY_E) BCD_preset <= 8'h00;
        else mode <= cand == KEY_A ? MODE_A : cand == KEY_B ? MODE_B : cand == KEY_C ? MODE_C : cand == KEY_D ? MODE_D : MODE_OFF;
      end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry with a 4-cycle column period and 3-frame debounce
module tb_keypad_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row_in, col_out, key_code, mode;
  logic key_valid;
  logic [7:0] BCD_preset;
  logic [15:0] keys = '0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_e;
  int errs = 0;
  int checks = 0;
  keypad_entry #(.SCAN_CNTMAX(3), .DEBOUNCE_FRAMES(3)) dut (
    .clk_50M(clk),
    .rst(rst),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .mode(mode),
    .BCD_preset(BCD_preset)
  );
  always #5 clk = ~clk;
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] oh(input logic [3:0] k);
    int p;
    case (k)
      4'h1: p = 0; 4'h2: p = 1; 4'h3: p = 2; 4'hA: p = 3;
      4'h4: p = 4; 4'h5: p = 5; 4'h6: p = 6; 4'hB: p = 7;
      4'h7: p = 8; 4'h8: p = 9; 4'h9: p = 10; 4'hC: p = 11;
      4'hE: p = 12; 4'h0: p = 13; 4'hF: p = 14; default: p = 15;
    endcase
    return 16'd1 << p;
  endfunction
  task automatic expect_key(input logic [3:0] k, input logic [3:0] m, input logic [7:0] p);
    exp_q.push_back({k, m, p});
  endtask
  task automatic frames(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (col_out != 4'b0111 && t < 40) begin @(negedge clk); t++; end
      while (col_out != 4'b1110 && t < 40) begin @(negedge clk); t++; end
      if (t >= 40) chk("frame_timeout", t, 0);
    end
  endtask
  task automatic tap(input logic [3:0] k, input int n);
    keys = oh(k);
    frames(n);
    keys = '0;
    frames(4);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, col_out, 4'b1110);
    chk({tag, "_code"}, key_code, 0);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_preset"}, BCD_preset, 8'h00);
  endtask
  always @(negedge clk)
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) chk("strobe_expected", 32'(key_valid), 0);
      else begin
        exp_e = exp_q.pop_front();
        chk("key_code", key_code, exp_e[15:12]);
        chk("mode", mode, exp_e[11:8]);
        chk("preset", BCD_preset, exp_e[7:0]);
      end
    end
  initial begin
    logic [3:0] ec;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      ec = 4'b1111;
      ec[(k / 4) % 4] = 1'b0;
      chk("col_scan", col_out, ec);
    end
    frames(3);
    chk("idle_mode", mode, 0);
    chk("idle_preset", BCD_preset, 8'h00);
    expect_key(4'h5, 4'b0000, 8'h05);
    tap(4'h5, 6);
    expect_key(4'h7, 4'b0000, 8'h57);
    tap(4'h7, 4);
    expect_key(4'h2, 4'b0000, 8'h72);
    tap(4'h2, 4);
    chk("digits_drain", exp_q.size(), 0);
    expect_key(4'h3, 4'b0000, 8'h23);
    keys = oh(4'h3);
    frames(2);
    keys = '0;
    frames(1);
    keys = oh(4'h3);
    frames(2);
    chk("bounce_not_early", exp_q.size(), 1);
    frames(1);
    @(negedge clk);
    chk("bounce_confirmed", exp_q.size(), 0);
    keys = '0;
    frames(1);
    keys = oh(4'h3);
    frames(3);
    keys = '0;
    frames(4);
    expect_key(4'hB, 4'b0010, 8'h23);
    tap(4'hB, 4);
    expect_key(4'hE, 4'b0010, 8'h00);
    tap(4'hE, 4);
    expect_key(4'hF, 4'b0000, 8'h00);
    tap(4'hF, 4);
    chk("func_drain", exp_q.size(), 0);
    keys = oh(4'h1) | oh(4'h2);
    frames(10);
    chk("multi_code", key_code, 4'hF);
    chk("multi_mode", mode, 0);
    chk("multi_preset", BCD_preset, 8'h00);
    expect_key(4'h1, 4'b0000, 8'h01);
    keys = oh(4'h1);
    frames(3);
    @(negedge clk);
    chk("multi_release", exp_q.size(), 0);
    keys = '0;
    frames(4);
    expect_key(4'h9, 4'b0000, 8'h19);
    keys = oh(4'h9);
    frames(4);
    chk("held_nine", exp_q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midreset");
    expect_key(4'h9, 4'b0000, 8'h09);
    frames(3);
    @(negedge clk);
    chk("reconfirm", exp_q.size(), 0);
    keys = '0;
    frames(4);
    chk("final_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
